// File: rtl/multicyc_mem_port_pkg.sv
// Shared types and constants for the multicycle core's memory access unit.
//   mem_port_state_t : access sequencer states
//   mem_target_t     : where the read data of an access lands
//   AddrPC/AddrALUout: encodings of the controller's mem_addr_sel select
//   pick_target()    : resolves simultaneous requests (store > load > fetch)
// Optional feature macro used by the files that import this package: MEM_TIMEOUT_EN.
package multicyc_mem_port_pkg;

  typedef enum logic [1:0] {
    MP_IDLE = 2'd0,
    MP_BUSY = 2'd1,
    MP_DONE = 2'd2
  } mem_port_state_t;

  typedef enum logic [1:0] {
    TGT_NONE = 2'd0,
    TGT_IR   = 2'd1,
    TGT_MDR  = 2'd2
  } mem_target_t;

  localparam logic AddrPC     = 1'b0;
  localparam logic AddrALUout = 1'b1;

  // A store captures nothing, so it maps to TGT_NONE even if a fetch or
  // load is requested in the same cycle.
  function automatic mem_target_t pick_target(input logic ir_we,
                                              input logic mem_rd,
                                              input logic mem_wr);
    mem_target_t tgt;
    if (mem_wr)      tgt = TGT_NONE;
    else if (mem_rd) tgt = TGT_MDR;
    else if (ir_we)  tgt = TGT_IR;
    else             tgt = TGT_NONE;
    return tgt;
  endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// BUSY-cycle watchdog for multicyc_mem_port (only instantiated when
// MEM_TIMEOUT_EN is defined).
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   load_i       : entering BUSY this edge; reload the counter
//   en_i         : currently in BUSY
//   tc_o         : this is the TIMEOUT_CYC-th BUSY cycle without ack
module mem_timeout_cnt #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Down-counter: loaded with TIMEOUT_CYC-1 so that it hits zero in the
  // TIMEOUT_CYC-th BUSY cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = CNT_W'(TIMEOUT_CYC - 1);
    else if (en_i && (cnt_q != '0))
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign tc_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/multicyc_mem_port.sv
// Memory access unit between the multicycle controller and a variable-latency
// req/ack bus. Owns the instruction register (instr) and memory data register
// (mdr); holds stall high until each access completes.
// Ports:
//   clk, reset_n             : clock, synchronous active-low reset
//   pc, alu_out, wr_data     : fetch address, load/store address, store data
//   mem_addr_sel             : AddrPC / AddrALUout
//   ir_we, mem_rd, mem_wr    : fetch / load / store requests
//   stall                    : controller must hold state
//   instr, mdr               : captured instruction / load data
//   bus_req/we/addr/wdata    : bus request side (address/data latched)
//   bus_ack, bus_rdata       : bus completion strobe and read data
//   bus_err                  : sticky timeout flag (MEM_TIMEOUT_EN only)
// Build option: MEM_TIMEOUT_EN adds the BUSY watchdog, TIMEOUT_CYC and bus_err.
//
// state   | meaning
// MP_IDLE | waiting for a request; stall follows the request lines
// MP_BUSY | bus_req high, waiting for bus_ack (or timeout)
// MP_DONE | access finished, stall low for one cycle so the controller advances
module multicyc_mem_port
  import multicyc_mem_port_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 64
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              mem_addr_sel,
  input  logic              ir_we,
  input  logic              mem_rd,
  input  logic              mem_wr,
  output logic              stall,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] mdr,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
`ifdef MEM_TIMEOUT_EN
  ,
  output logic              bus_err
`endif
);

  mem_port_state_t state_q, state_d;
  mem_target_t     target_q, target_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              any_req;

  assign any_req = ir_we | mem_rd | mem_wr;

`ifdef MEM_TIMEOUT_EN
  logic err_q, err_d;
  logic tmo_tc;

  mem_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  ((state_q == MP_IDLE) && any_req),
    .en_i    (state_q == MP_BUSY),
    .tc_o    (tmo_tc)
  );
`endif

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    instr_d  = instr_q;
    mdr_d    = mdr_q;
    stall    = 1'b0;
    bus_req  = 1'b0;
`ifdef MEM_TIMEOUT_EN
    err_d    = err_q;
`endif
    case (state_q)
      MP_IDLE: begin
        if (any_req) begin
          stall    = 1'b1;
          state_d  = MP_BUSY;
          we_d     = mem_wr;
          wdata_d  = wr_data;
          target_d = pick_target(ir_we, mem_rd, mem_wr);
          case (mem_addr_sel)
            AddrPC:     addr_d = pc;
            AddrALUout: addr_d = alu_out;
          endcase
        end
      end
      MP_BUSY: begin
        stall   = 1'b1;
        bus_req = 1'b1;
        if (bus_ack) begin
          state_d = MP_DONE;
          if (target_q == TGT_IR)  instr_d = bus_rdata;
          if (target_q == TGT_MDR) mdr_d   = bus_rdata;
        end
`ifdef MEM_TIMEOUT_EN
        // A zero instruction is the sll NOP, so a failed fetch executes harmlessly.
        else if (tmo_tc) begin
          state_d = MP_DONE;
          err_d   = 1'b1;
          if (target_q == TGT_IR)  instr_d = '0;
          if (target_q == TGT_MDR) mdr_d   = '0;
        end
`endif
      end
      MP_DONE: state_d = MP_IDLE;
      default: state_d = MP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= MP_IDLE;
      target_q <= TGT_NONE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      instr_q  <= '0;
      mdr_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      instr_q  <= instr_d;
      mdr_q    <= mdr_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign bus_err = err_q;
`endif

  assign instr     = instr_q;
  assign mdr       = mdr_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_multicyc_mem_port.sv
// Directed bench for multicyc_mem_port. Inputs change 1 ns after each rising
// edge; outputs are sampled at the same point. Build with MEM_TIMEOUT_EN to
// also exercise the watchdog (TIMEOUT_CYC = 8).
module tb_multicyc_mem_port;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc, alu_out, wr_data;
  logic        mem_addr_sel, ir_we, mem_rd, mem_wr;
  logic        stall;
  logic [31:0] instr, mdr;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
`ifdef MEM_TIMEOUT_EN
  logic        bus_err;
`endif

  int n_vec = 0;
  int n_err = 0;
  int req_cyc, stall_cyc;

  always #5 clk = ~clk;

  multicyc_mem_port #(
    .ADDR_W (32),
    .DATA_W (32)
`ifdef MEM_TIMEOUT_EN
    ,
    .TIMEOUT_CYC (8)
`endif
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pc           (pc),
    .alu_out      (alu_out),
    .wr_data      (wr_data),
    .mem_addr_sel (mem_addr_sel),
    .ir_we        (ir_we),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .stall        (stall),
    .instr        (instr),
    .mdr          (mdr),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_ack      (bus_ack),
    .bus_rdata    (bus_rdata)
`ifdef MEM_TIMEOUT_EN
    ,
    .bus_err      (bus_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the request (IDLE) cycle with the request lines already set.
  // Scrambles controller inputs once BUSY is entered, acks in BUSY cycle
  // ack_at (never if out of range), returns in the DONE cycle.
  task automatic run_access(input int ack_at, input logic [31:0] rdata,
                            output int rc, output int sc);
    sc = stall ? 1 : 0;
    tick();
    ir_we        = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    pc           = 32'hFFFF_FFF0;
    alu_out      = 32'hFFFF_FFE0;
    wr_data      = 32'hA5A5_A5A5;
    mem_addr_sel = ~mem_addr_sel;
    rc = 0;
    while (bus_req && rc < 100) begin
      rc++;
      if (stall) sc++;
      bus_ack   = (rc == ack_at);
      bus_rdata = rdata;
      tick();
      bus_ack   = 1'b0;
      bus_rdata = '0;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, {31'b0, stall}, 32'h0);
    chk({tag, "_req"},   {31'b0, bus_req}, 32'h0);
    chk({tag, "_we"},    {31'b0, bus_we}, 32'h0);
    chk({tag, "_addr"},  bus_addr, 32'h0);
    chk({tag, "_wdata"}, bus_wdata, 32'h0);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_mdr"},   mdr, 32'h0);
`ifdef MEM_TIMEOUT_EN
    chk({tag, "_err"},   {31'b0, bus_err}, 32'h0);
`endif
  endtask

  initial begin
    reset_n = 1'b0; pc = '0; alu_out = '0; wr_data = '0; mem_addr_sel = 1'b0;
    ir_we = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    tick(); tick();
    reset_n = 1'b1;
    chk_all_zero("rst");

    // 1: zero-wait fetch
    ir_we = 1'b1; pc = 32'h40; mem_addr_sel = 1'b0;
    #1 chk("f_req_stall", {31'b0, stall}, 32'h1);
    run_access(1, 32'h2008_0005, req_cyc, stall_cyc);
    chk("f_busy_cyc",  req_cyc, 1);
    chk("f_stall_cyc", stall_cyc, 2);
    chk("f_done_stall", {31'b0, stall}, 32'h0);
    chk("f_done_req",  {31'b0, bus_req}, 32'h0);
    chk("f_addr",      bus_addr, 32'h40);
    chk("f_we",        {31'b0, bus_we}, 32'h0);
    chk("f_instr",     instr, 32'h2008_0005);
    tick();

    // 2: load with 3 wait states
    mem_rd = 1'b1; mem_addr_sel = 1'b1; alu_out = 32'h100;
    run_access(4, 32'hDEAD_BEEF, req_cyc, stall_cyc);
    chk("ld_busy_cyc", req_cyc, 4);
    chk("ld_total",    req_cyc + 2, 6);
    chk("ld_addr",     bus_addr, 32'h100);
    chk("ld_mdr",      mdr, 32'hDEAD_BEEF);
    chk("ld_instr",    instr, 32'h2008_0005);
    tick();

    // 3: store, read data on the bus must not be captured
    mem_wr = 1'b1; mem_addr_sel = 1'b1; alu_out = 32'h200; wr_data = 32'h1234;
    run_access(2, 32'hFFFF_FFFF, req_cyc, stall_cyc);
    chk("st_busy_cyc", req_cyc, 2);
    chk("st_we",       {31'b0, bus_we}, 32'h1);
    chk("st_wdata",    bus_wdata, 32'h1234);
    chk("st_addr",     bus_addr, 32'h200);
    chk("st_mdr",      mdr, 32'hDEAD_BEEF);
    chk("st_instr",    instr, 32'h2008_0005);
    tick();

    // unaligned fetch address passes through unchanged
    ir_we = 1'b1; mem_addr_sel = 1'b0; pc = 32'h43;
    run_access(3, 32'h0123_4567, req_cyc, stall_cyc);
    chk("ua_addr",  bus_addr, 32'h43);
    chk("ua_instr", instr, 32'h0123_4567);
    tick();

    // 5: simultaneous requests resolve to a store
    ir_we = 1'b1; mem_rd = 1'b1; mem_wr = 1'b1;
    mem_addr_sel = 1'b1; pc = 32'h80; alu_out = 32'h300; wr_data = 32'h55;
    run_access(2, 32'h7777_7777, req_cyc, stall_cyc);
    chk("sim_we",    {31'b0, bus_we}, 32'h1);
    chk("sim_addr",  bus_addr, 32'h300);
    chk("sim_wdata", bus_wdata, 32'h55);
    chk("sim_instr", instr, 32'h0123_4567);
    chk("sim_mdr",   mdr, 32'hDEAD_BEEF);

    // request raised in DONE is only seen in the following IDLE cycle
    ir_we = 1'b1; mem_addr_sel = 1'b0; pc = 32'h44;
    tick();
    chk("dn_idle_req",   {31'b0, bus_req}, 32'h0);
    chk("dn_idle_stall", {31'b0, stall}, 32'h1);
    tick();
    ir_we = 1'b0;
    chk("dn_busy_req",  {31'b0, bus_req}, 32'h1);
    chk("dn_busy_addr", bus_addr, 32'h44);

    // 4: reset during BUSY, then a late ack in IDLE
    reset_n = 1'b0;
    tick();
    chk_all_zero("mid_rst");
    reset_n = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hAAAA_5555;
    tick();
    bus_ack = 1'b0; bus_rdata = '0;
    chk_all_zero("late_ack");

`ifdef MEM_TIMEOUT_EN
    // 6: watchdog on a fetch
    ir_we = 1'b1; pc = 32'h8;
    run_access(1, 32'h1111_2222, req_cyc, stall_cyc);
    chk("pre_instr", instr, 32'h1111_2222);
    chk("pre_err",   {31'b0, bus_err}, 32'h0);
    tick();
    ir_we = 1'b1; pc = 32'hC;
    run_access(1000, 32'h0, req_cyc, stall_cyc);
    chk("to_busy_cyc", req_cyc, 8);
    chk("to_req",      {31'b0, bus_req}, 32'h0);
    chk("to_stall",    {31'b0, stall}, 32'h0);
    chk("to_err",      {31'b0, bus_err}, 32'h1);
    chk("to_instr",    instr, 32'h0);
    tick();
    mem_rd = 1'b1; mem_addr_sel = 1'b1; alu_out = 32'h10;
    run_access(1, 32'h3333_4444, req_cyc, stall_cyc);
    chk("to_ld_mdr",   mdr, 32'h3333_4444);
    chk("to_err_stk",  {31'b0, bus_err}, 32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
